// File: rtl/uart_rx.sv
// uart_rx - UART receive engine driven by a 16x oversampling tick.
// The frame format is set at runtime: 5-8 data bits, optional even or odd
// parity, and 1 or 2 stop bits.
//
// Ports:
//   clk, rst_n     system clock, asynchronous active-low reset
//   tick           one-clk pulse at 16x baud; every FSM step waits for it
//   rx             serial input, idle high, LSB first
//   data_bit_num   number of data bits minus 5
//   stop_bit_num   0 = 1 stop bit, 1 = 2 stop bits
//   parity_en      a parity bit follows the data bits
//   parity_type    0 = even, 1 = odd
//   rts_n          host ready-to-receive, active low
//   rx_done        level flag; high from frame completion until the next start bit
//   cts_n          registered copy of rts_n
//   parity_error   parity mismatch on the last completed frame
//   rx_data        last character, right-aligned, upper bits zero
module uart_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       rx,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       rts_n,
  output logic       rx_done,
  output logic       cts_n,
  output logic       parity_error,
  output logic [7:0] rx_data
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t     state_q;
  logic [3:0] s_cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q;
  logic       par_bit_q;
  logic       stop2_q;     // set while counting the second stop bit
  logic       rx_done_q;
  logic       perr_q;
  logic [7:0] rx_data_q;
  logic       cts_q;

  logic [2:0] last_idx;
  logic       par_exp;

  assign last_idx = {1'b0, data_bit_num} + 3'd4;
  // The shift register is cleared at the start of the data phase, so unused
  // upper bits are zero and XOR over all 8 bits gives the parity of N bits.
  assign par_exp  = (^shift_q) ^ parity_type;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      s_cnt_q   <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      par_bit_q <= 1'b0;
      stop2_q   <= 1'b0;
      rx_done_q <= 1'b0;
      perr_q    <= 1'b0;
      rx_data_q <= '0;
      cts_q     <= 1'b1;
    end else begin
      cts_q <= rts_n;
      if (tick) begin
        case (state_q)
          IDLE: begin
            if (!rx) begin
              state_q   <= START;
              s_cnt_q   <= '0;
              rx_done_q <= 1'b0;
            end
          end
          START: begin
            if (s_cnt_q == 4'd7) begin
              // Check the line again at mid start bit to reject glitches.
              if (!rx) begin
                state_q <= DATA;
                s_cnt_q <= '0;
                idx_q   <= '0;
                shift_q <= '0;
              end else begin
                state_q <= IDLE;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 4'd1;
            end
          end
          DATA: begin
            if (s_cnt_q == 4'd15) begin
              s_cnt_q        <= '0;
              shift_q[idx_q] <= rx;
              if (idx_q == last_idx) begin
                state_q <= parity_en ? PARITY : STOP;
                stop2_q <= 1'b0;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 4'd1;
            end
          end
          PARITY: begin
            if (s_cnt_q == 4'd15) begin
              s_cnt_q   <= '0;
              par_bit_q <= rx;
              state_q   <= STOP;
              stop2_q   <= 1'b0;
            end else begin
              s_cnt_q <= s_cnt_q + 4'd1;
            end
          end
          STOP: begin
            if (s_cnt_q == 4'd15) begin
              s_cnt_q <= '0;
              if (stop_bit_num && !stop2_q) begin
                stop2_q <= 1'b1;
              end else begin
                rx_data_q <= shift_q;
                perr_q    <= parity_en & (par_bit_q != par_exp);
                rx_done_q <= 1'b1;
                state_q   <= IDLE;
              end
            end else begin
              s_cnt_q <= s_cnt_q + 4'd1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rx_done      = rx_done_q;
  assign cts_n        = cts_q;
  assign parity_error = perr_q;
  assign rx_data      = rx_data_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed frames from the test plan plus random
// frames, compared against a frame-level reference model.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic       rx;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       rts_n;
  logic       rx_done;
  logic       cts_n;
  logic       parity_error;
  logic [7:0] rx_data;

  int n_assert = 0;
  int n_fail   = 0;

  logic [1:0] tcnt = 2'd0;

  uart_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .rx           (rx),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .rts_n        (rts_n),
    .rx_done      (rx_done),
    .cts_n        (cts_n),
    .parity_error (parity_error),
    .rx_data      (rx_data)
  );

  always #5 clk = ~clk;

  // 16x tick: one pulse every 4 clocks.
  always @(posedge clk) tcnt <= tcnt + 2'd1;
  assign tick = (tcnt == 2'd3);

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns at the falling edge that follows the next tick-qualified edge.
  task automatic one_tick();
    @(negedge clk);
    while (!tick) @(negedge clk);
    @(negedge clk);
  endtask

  task automatic hold_rx(input logic v, input int ticks);
    rx = v;
    repeat (ticks) one_tick();
  endtask

  // Reference model: what the receiver reports after a frame.
  function automatic logic [7:0] model_data(input int nbits, input logic [7:0] d);
    return d & 8'((1 << nbits) - 1);
  endfunction

  function automatic logic model_perr(input int nbits, input logic pen, input logic ptype,
                                      input logic pbit, input logic [7:0] d);
    logic [7:0] m;
    m = model_data(nbits, d);
    if (!pen) return 1'b0;
    return pbit != logic'(($countones(m) % 2) ^ int'(ptype));
  endfunction

  // Sends one complete frame, then checks the outputs against the model.
  task automatic send_frame(input string tag, input logic [1:0] dbn, input logic pen,
                            input logic ptype, input logic sb2, input logic [7:0] d,
                            input logic pbit);
    logic bits[$];
    int   nbits;
    nbits        = int'(dbn) + 5;
    data_bit_num = dbn;
    parity_en    = pen;
    parity_type  = ptype;
    stop_bit_num = sb2;
    for (int i = 0; i < nbits; i++) bits.push_back(d[i]);
    if (pen) bits.push_back(pbit);
    bits.push_back(1'b1);
    if (sb2) bits.push_back(1'b1);
    hold_rx(1'b0, 16);
    chk({tag, "_done_clr"}, {7'd0, rx_done}, 8'd0);
    foreach (bits[i]) hold_rx(bits[i], 16);
    // Idle long enough to cover the stop-bit completion latency.
    hold_rx(1'b1, 40);
    chk({tag, "_done"}, {7'd0, rx_done}, 8'd1);
    chk({tag, "_data"}, rx_data, model_data(nbits, d));
    chk({tag, "_perr"}, {7'd0, parity_error},
        {7'd0, model_perr(nbits, pen, ptype, pbit, d)});
  endtask

  initial begin
    logic [7:0] d;
    logic [1:0] dbn;
    logic       pen, ptype, sb2, pbit;
    rst_n = 1'b0;
    rx = 1'b1;
    data_bit_num = 2'd3;
    stop_bit_num = 1'b0;
    parity_en = 1'b0;
    parity_type = 1'b0;
    rts_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_data", rx_data, 8'h00);
    chk("rst_done", {7'd0, rx_done}, 8'd0);
    chk("rst_perr", {7'd0, parity_error}, 8'd0);
    chk("rst_cts", {7'd0, cts_n}, 8'd1);
    rst_n = 1'b1;
    hold_rx(1'b1, 20);

    // Directed test-plan frames.
    send_frame("8N1_A5", 2'd3, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0);
    send_frame("7E1_55", 2'd2, 1'b1, 1'b0, 1'b0, 8'h55, 1'b0);
    send_frame("6O2_2A", 2'd1, 1'b1, 1'b1, 1'b1, 8'h2A, 1'b0);
    send_frame("5N2_1B", 2'd0, 1'b0, 1'b0, 1'b1, 8'h1B, 1'b0);
    send_frame("8E1_01", 2'd3, 1'b1, 1'b0, 1'b0, 8'h01, 1'b0);

    // A 4-tick low glitch clears rx_done but must not complete a frame.
    hold_rx(1'b0, 4);
    hold_rx(1'b1, 40);
    chk("glitch_done", {7'd0, rx_done}, 8'd0);
    chk("glitch_data", rx_data, 8'h01);
    chk("glitch_perr", {7'd0, parity_error}, 8'd1);

    // Flow control: cts_n follows rts_n one clock later.
    rts_n = 1'b0;
    chk("cts_hold1", {7'd0, cts_n}, 8'd1);
    @(negedge clk);
    chk("cts_fall", {7'd0, cts_n}, 8'd0);
    rts_n = 1'b1;
    chk("cts_hold0", {7'd0, cts_n}, 8'd0);
    @(negedge clk);
    chk("cts_rise", {7'd0, cts_n}, 8'd1);

    // Reset in the middle of a frame.
    data_bit_num = 2'd3;
    parity_en = 1'b0;
    stop_bit_num = 1'b0;
    hold_rx(1'b0, 16);
    hold_rx(1'b1, 16);
    hold_rx(1'b0, 8);
    rts_n = 1'b0;
    rst_n = 1'b0;
    rx = 1'b1;
    @(negedge clk);
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_done", {7'd0, rx_done}, 8'd0);
    chk("mrst_perr", {7'd0, parity_error}, 8'd0);
    chk("mrst_cts", {7'd0, cts_n}, 8'd1);
    rst_n = 1'b1;
    hold_rx(1'b1, 200);
    chk("mrst_nodone", {7'd0, rx_done}, 8'd0);
    rts_n = 1'b1;
    send_frame("post_rst", 2'd3, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0);

    // Random frames: random format, data and parity bit.
    for (int k = 0; k < 14; k++) begin
      d     = 8'($urandom);
      dbn   = 2'($urandom_range(0, 3));
      pen   = 1'($urandom);
      ptype = 1'($urandom);
      sb2   = 1'($urandom);
      pbit  = 1'($urandom);
      send_frame($sformatf("rnd%0d", k), dbn, pen, ptype, sb2, d, pbit);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
